// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared constants, frame field positions and FSM encoding for mdio_arbiter
package mdio_pkg;

    localparam logic [1:0] ST_SOF   = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam int ST_MSB    = 31;
    localparam int ST_LSB    = 30;
    localparam int OP_MSB    = 29;
    localparam int OP_LSB    = 28;
    localparam int PHYAD_MSB = 27;
    localparam int PHYAD_LSB = 23;
    localparam int REGAD_MSB = 22;
    localparam int REGAD_LSB = 18;
    localparam int TA_MSB    = 17;
    localparam int TA_LSB    = 16;
    localparam int WDATA_MSB = 15;
    localparam int WDATA_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_RESP = 3'd3,
        S_GAP  = 3'd4
    } mdio_state_t;

    // A frame is accepted only with a valid start-of-frame and a read or write opcode.
    function automatic logic frame_ok(input logic [31:0] f);
        return (f[ST_MSB:ST_LSB] == ST_SOF) &&
               ((f[OP_MSB:OP_LSB] == OP_READ) || (f[OP_MSB:OP_LSB] == OP_WRITE));
    endfunction

endpackage

// File: rtl/mdio_rr_grant.sv
// rtl/mdio_rr_grant.sv - combinational one-hot grant with rotating start pointer
// Ports: i_req (request vector), i_ptr (search start), o_grant (one-hot winner),
//        o_any (some request present), o_idx (winner index), o_next_ptr (winner+1 wrapped).
// Macro MDIO_ARB_FIXED_PRIO_EN: search always starts at index 0 and o_next_ptr is tied to 0.
module mdio_rr_grant #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_any,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic [$clog2(N_REQ)-1:0] o_next_ptr
);

    localparam int PW = $clog2(N_REQ);

    logic [PW:0] w_j;
    logic        w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef MDIO_ARB_FIXED_PRIO_EN
            w_j = (PW+1)'(k);
`else
            // Candidate index (ptr + k) mod N_REQ without a divider.
            w_j = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_j >= (PW+1)'(N_REQ)) begin
                w_j = w_j - (PW+1)'(N_REQ);
            end
`endif
            if (!w_found && i_req[w_j[PW-1:0]]) begin
                w_found              = 1'b1;
                o_idx                = w_j[PW-1:0];
                o_grant[w_j[PW-1:0]] = 1'b1;
            end
        end
    end

    assign o_any = w_found;

`ifdef MDIO_ARB_FIXED_PRIO_EN
    assign o_next_ptr = '0;
`else
    assign o_next_ptr = (o_idx == PW'(N_REQ - 1)) ? '0 : o_idx + 1'b1;
`endif

endmodule

// File: rtl/mdio_arbiter.sv
// rtl/mdio_arbiter.sv - shares one MDIO controller between N_REQ requesters, one frame in flight
// Ports: CLK, RESET (sync, active-low); REQ_VALID/REQ_FRAME/REQ_READY requester side;
//        RSP_VALID/RSP_DATA/RSP_ERR responses; BUSY; MDIO_START/T_DATA/RD_DATA/DATA_RDY controller side.
// Macro MDIO_ARB_FIXED_PRIO_EN: lowest index always wins, no rotating pointer register.
module mdio_arbiter
    import mdio_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int FRAME_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 80,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N_REQ-1:0]     REQ_VALID,
    input  logic [32*N_REQ-1:0]  REQ_FRAME,
    output logic [N_REQ-1:0]     REQ_READY,
    output logic [N_REQ-1:0]     RSP_VALID,
    output logic [15:0]          RSP_DATA,
    output logic                 RSP_ERR,
    output logic                 BUSY,
    output logic                 MDIO_START,
    output logic [31:0]          T_DATA,
    input  logic [15:0]          RD_DATA,
    input  logic                 DATA_RDY
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(N_REQ);

    mdio_state_t       r_state, w_state_nx;
    logic [31:0]       r_frame, w_frame_nx;
    logic [PW-1:0]     r_idx, w_idx_nx;
    logic [CW-1:0]     r_cnt, w_cnt_nx;
    logic [15:0]       r_rsp_data, w_rsp_data_nx;
    logic              r_rsp_err, w_rsp_err_nx;

    logic [N_REQ-1:0]  w_grant;
    logic              w_any;
    logic [PW-1:0]     w_gnt_idx;
    logic [PW-1:0]     w_next_ptr;
    logic [PW-1:0]     w_ptr;
    logic              w_is_read;

    mdio_rr_grant #(
        .N_REQ (N_REQ)
    ) u_grant (
        .i_req      (REQ_VALID),
        .i_ptr      (w_ptr),
        .o_grant    (w_grant),
        .o_any      (w_any),
        .o_idx      (w_gnt_idx),
        .o_next_ptr (w_next_ptr)
    );

`ifdef MDIO_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [PW-1:0] r_ptr;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_ptr <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_ptr <= w_next_ptr;
        end
    end

    assign w_ptr = r_ptr;
`endif

    assign w_is_read = (r_frame[OP_MSB:OP_LSB] == OP_READ);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_frame    <= w_frame_nx;
            r_idx      <= w_idx_nx;
            r_cnt      <= w_cnt_nx;
            r_rsp_data <= w_rsp_data_nx;
            r_rsp_err  <= w_rsp_err_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_frame_nx    = r_frame;
        w_idx_nx      = r_idx;
        w_cnt_nx      = r_cnt;
        w_rsp_data_nx = r_rsp_data;
        w_rsp_err_nx  = r_rsp_err;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_frame_nx = REQ_FRAME[32*w_gnt_idx +: 32];
                    w_idx_nx   = w_gnt_idx;
                    w_state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!frame_ok(r_frame)) begin
                    w_rsp_data_nx = '0;
                    w_rsp_err_nx  = 1'b1;
                    w_state_nx    = S_RESP;
                end else begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                w_cnt_nx = r_cnt + 1'b1;
                if (w_is_read) begin
                    // DATA_RDY is checked first so it wins over a coincident timeout.
                    if (DATA_RDY) begin
                        w_rsp_data_nx = RD_DATA;
                        w_rsp_err_nx  = 1'b0;
                        w_state_nx    = S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        w_rsp_data_nx = '0;
                        w_rsp_err_nx  = 1'b1;
                        w_state_nx    = S_RESP;
                    end
                end else if (r_cnt == CW'(FRAME_CYCLES - 1)) begin
                    w_rsp_data_nx = '0;
                    w_rsp_err_nx  = 1'b0;
                    w_state_nx    = S_RESP;
                end
            end
            S_RESP: begin
                w_cnt_nx   = '0;
                w_state_nx = S_GAP;
            end
            S_GAP: begin
                if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Accept is combinational in IDLE; gated by RESET so nothing is offered while held in reset.
    assign REQ_READY  = (r_state == S_IDLE && RESET) ? w_grant : '0;
    assign RSP_VALID  = (r_state == S_RESP) ? (N_REQ'(1) << r_idx) : '0;
    assign RSP_DATA   = r_rsp_data;
    assign RSP_ERR    = r_rsp_err;
    assign BUSY       = (r_state != S_IDLE);
    assign MDIO_START = (r_state == S_RUN);
    assign T_DATA     = r_frame;

endmodule

// File: tb/tb_mdio_arbiter.sv
// tb/tb_mdio_arbiter.sv - randomized self-checking bench for mdio_arbiter against a transaction timeline model
module tb_mdio_arbiter;

    localparam int N        = 4;
    localparam int FRAME    = 64;
    localparam int TMO      = 80;
    localparam int GAP      = 2;
    localparam int RAND_END = 20000;
    localparam int MAXC     = 40000;

    typedef struct {
        logic [31:0] frame;
        int          k;
        logic [15:0] rd;
    } req_t;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [N-1:0]    REQ_VALID;
    logic [32*N-1:0] REQ_FRAME;
    logic [N-1:0]    REQ_READY;
    logic [N-1:0]    RSP_VALID;
    logic [15:0]     RSP_DATA;
    logic            RSP_ERR;
    logic            BUSY;
    logic            MDIO_START;
    logic [31:0]     T_DATA;
    logic [15:0]     RD_DATA;
    logic            DATA_RDY;

    always #5 CLK = ~CLK;

    mdio_arbiter #(
        .N_REQ          (N),
        .FRAME_CYCLES   (FRAME),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ_VALID  (REQ_VALID),
        .REQ_FRAME  (REQ_FRAME),
        .REQ_READY  (REQ_READY),
        .RSP_VALID  (RSP_VALID),
        .RSP_DATA   (RSP_DATA),
        .RSP_ERR    (RSP_ERR),
        .BUSY       (BUSY),
        .MDIO_START (MDIO_START),
        .T_DATA     (T_DATA),
        .RD_DATA    (RD_DATA),
        .DATA_RDY   (DATA_RDY)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    req_t q[N][$];

    // Transaction timeline model: every expectation is a cycle number derived from the grant cycle.
    int          m_ptr;
    int          m_free;
    logic [31:0] m_tdata;
    logic [15:0] m_rdata, m_pdata, m_rd_val;
    logic        m_rerr, m_perr, m_rd_active;
    int          m_rsp_cyc, m_rsp_idx, m_win_lo, m_win_hi, m_rdy_cyc;

    task automatic model_reset(input int n);
        m_ptr       = 0;
        m_free      = n + 1;
        m_tdata     = '0;
        m_rdata     = '0;
        m_rerr      = 1'b0;
        m_rsp_cyc   = -1;
        m_win_lo    = -1;
        m_win_hi    = -2;
        m_rd_active = 1'b0;
        m_rdy_cyc   = -1;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   c;
        c       = $urandom_range(0, 7);
        r.frame = $urandom;
        if (c <= 2) r.frame[31:28] = 4'b0101;
        else if (c <= 5) r.frame[31:28] = 4'b0110;
        else if (c == 6) begin
            r.frame[31:30] = 2'($urandom_range(0, 2));
            if (r.frame[31:30] == 2'b01) r.frame[31:30] = 2'b11;
        end else begin
            r.frame[31:30] = 2'b01;
            r.frame[29:28] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        end
        c   = $urandom_range(0, 9);
        r.k = (c == 0) ? TMO - 1 : (c == 1) ? 0 : (c == 2) ? TMO : $urandom_range(0, 99);
        r.rd = 16'($urandom);
        return r;
    endfunction

    task automatic push(input int i, input logic [31:0] f, input int k, input logic [15:0] rd);
        req_t r;
        r.frame = f;
        r.k     = k;
        r.rd    = rd;
        q[i].push_back(r);
    endtask

    function automatic bit quiet(input int n);
        for (int i = 0; i < N; i++) begin
            if (q[i].size() != 0 || REQ_VALID[i]) return 1'b0;
        end
        return (n >= m_free);
    endfunction

    initial begin
        int          n, step, e, start_cnt, gi;
        bit          rnd, done;
        bit          legal;
        logic [N-1:0] last_gnt, ev;
        logic [31:0] f;
        int          glog[$];
        int          exp_order[5];
        req_t        it;

`ifdef MDIO_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 2, 3};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        RESET     = 1'b0;
        REQ_VALID = '0;
        REQ_FRAME = '0;
        RD_DATA   = '0;
        DATA_RDY  = 1'b0;
        repeat (2) @(posedge CLK);
        model_reset(-1);
        last_gnt  = '0;
        n         = 0;
        step      = 0;
        rnd       = 1'b0;
        done      = 1'b0;
        start_cnt = 0;

        while (!done && n < MAXC) begin
            @(negedge CLK);
            RESET = 1'b1;
            if (step == 0 && n < 3) RESET = 1'b0;
            if (step == 5 && m_rd_active && n == m_win_lo + 30) RESET = 1'b0;

            if (quiet(n)) begin
                case (step)
                    0: if (n >= 4) begin
                        push(0, 32'h599ECCCF, 0, 16'h0);
                        start_cnt = 0;
                        step = 1;
                    end
                    1: begin
                        chk("write_start_len", start_cnt, FRAME);
                        push(1, 32'h699ECD3F, 60, 16'hB4C5);
                        step = 2;
                    end
                    2: begin
                        push(2, 32'hD99ECD3F, 0, 16'h0);
                        step = 3;
                    end
                    3: begin
                        push(3, 32'h699ECD3F, 200, 16'h1234);
                        start_cnt = 0;
                        step = 4;
                    end
                    4: begin
                        chk("timeout_start_len", start_cnt, TMO);
                        push(0, 32'h6A5A0000, 200, 16'h5555);
                        start_cnt = 0;
                        step = 5;
                    end
                    5: begin
                        chk("reset_abort_start_len", start_cnt, 31);
                        push(0, 32'h50000001, 0, 16'h0);
                        push(0, 32'h50000002, 0, 16'h0);
                        push(1, 32'h50000003, 0, 16'h0);
                        push(2, 32'h50000004, 0, 16'h0);
                        push(3, 32'h50000005, 0, 16'h0);
                        glog.delete();
                        step = 6;
                    end
                    6: begin
                        for (int i = 0; i < 5; i++) begin
                            gi = (i < glog.size()) ? glog[i] : -1;
                            chk($sformatf("grant_order[%0d]", i), gi, exp_order[i]);
                        end
                        rnd  = 1'b1;
                        step = 7;
                    end
                    default: if (n >= RAND_END) done = 1'b1;
                endcase
            end

            if (rnd && n < RAND_END) begin
                for (int i = 0; i < N; i++) begin
                    if (q[i].size() < 2 && $urandom_range(0, 39) == 0) q[i].push_back(rand_req());
                end
            end

            for (int i = 0; i < N; i++) begin
                if (last_gnt[i]) REQ_VALID[i] = 1'b0;
                if (REQ_VALID[i] && rnd && $urandom_range(0, 63) == 0) begin
                    REQ_VALID[i] = 1'b0;
                end else if (!REQ_VALID[i] && q[i].size() != 0 &&
                             (!rnd || $urandom_range(0, 3) == 0)) begin
                    REQ_VALID[i]          = 1'b1;
                    REQ_FRAME[32*i +: 32] = q[i][0].frame;
                end
            end

            if (m_rd_active && n >= m_win_lo && n <= m_win_hi) begin
                DATA_RDY = (n == m_rdy_cyc);
                RD_DATA  = (n == m_rdy_cyc) ? m_rd_val : 16'($urandom);
            end else begin
                DATA_RDY = ($urandom_range(0, 7) == 0);
                RD_DATA  = 16'($urandom);
            end

            #1;
            if (n == m_rsp_cyc) begin
                m_rdata = m_pdata;
                m_rerr  = m_perr;
            end
            e  = (RESET && n >= m_free) ? pick(REQ_VALID, m_ptr) : -1;
            ev = (n == m_rsp_cyc) ? (N'(1) << m_rsp_idx) : '0;
            chk($sformatf("req_ready@%0d", n), 32'(REQ_READY), (e >= 0) ? (32'd1 << e) : 32'd0);
            chk($sformatf("busy@%0d", n), 32'(BUSY), 32'(n < m_free));
            chk($sformatf("mdio_start@%0d", n), 32'(MDIO_START), 32'(n >= m_win_lo && n <= m_win_hi));
            chk($sformatf("t_data@%0d", n), T_DATA, m_tdata);
            chk($sformatf("rsp_valid@%0d", n), 32'(RSP_VALID), 32'(ev));
            chk($sformatf("rsp_data@%0d", n), 32'(RSP_DATA), 32'(m_rdata));
            chk($sformatf("rsp_err@%0d", n), 32'(RSP_ERR), 32'(m_rerr));

            if (MDIO_START) start_cnt++;
            if (step == 6) begin
                for (int i = 0; i < N; i++) if (REQ_READY[i]) glog.push_back(i);
            end

            last_gnt = '0;
            if (e >= 0) begin
                it = q[e].pop_front();
                f  = it.frame;
                last_gnt[e] = 1'b1;
                m_tdata     = f;
                m_rsp_idx   = e;
                legal = (f[31:30] == 2'b01) && (f[29:28] == 2'b10 || f[29:28] == 2'b01);
                m_rd_active = 1'b0;
                m_rdy_cyc   = -1;
                if (!legal) begin
                    m_win_lo = -1;  m_win_hi = -2;
                    m_rsp_cyc = n + 2;  m_pdata = '0;  m_perr = 1'b1;
                end else if (f[29:28] == 2'b01) begin
                    m_win_lo = n + 2;  m_win_hi = n + 1 + FRAME;
                    m_rsp_cyc = n + 2 + FRAME;  m_pdata = '0;  m_perr = 1'b0;
                end else if (it.k < TMO) begin
                    m_rd_active = 1'b1;  m_rdy_cyc = n + 2 + it.k;  m_rd_val = it.rd;
                    m_win_lo = n + 2;  m_win_hi = n + 2 + it.k;
                    m_rsp_cyc = n + 3 + it.k;  m_pdata = it.rd;  m_perr = 1'b0;
                end else begin
                    m_rd_active = 1'b1;
                    m_win_lo = n + 2;  m_win_hi = n + 1 + TMO;
                    m_rsp_cyc = n + 2 + TMO;  m_pdata = '0;  m_perr = 1'b1;
                end
                m_free = m_rsp_cyc + 1 + GAP;
`ifndef MDIO_ARB_FIXED_PRIO_EN
                m_ptr = (e + 1) % N;
`endif
            end
            if (!RESET) model_reset(n);
            n++;
        end

        chk("run_completed", 32'(done), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
